// File: rtl/load_return_aligner.sv
// Purpose: pairs returned data-SRAM words with queued load metadata and builds the aligned/extended writeback value.
// Latency: one cycle from the rdata handshake to out_valid; metadata FIFO holds up to DEPTH outstanding loads.
// Backpressure: req_ready drops when the FIFO is full; rdata_ready drops while the output register is held (out_valid && !out_ready).
module load_return_aligner #(
    parameter int DEPTH = 2,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_op,
    input  logic [1:0]       req_addr_lo,
    input  logic [31:0]      req_rt,
    input  logic [REG_W-1:0] req_wreg,
    input  logic             rdata_valid,
    output logic             rdata_ready,
    input  logic [31:0]      rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_wdata,
    output logic [REG_W-1:0] out_wreg,
    output logic             out_misalign,
    output logic             resp_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Per-load metadata captured at issue time. op is one-hot {lwl,lwr,lb,lbu,lh,lhu,lw}.
    typedef struct packed {
        logic [6:0]       op;
        logic [1:0]       lo;
        logic [31:0]      rt;
        logic [REG_W-1:0] wreg;
    } meta_t;

    meta_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    logic  orphan;
    meta_t head;
    meta_t wr_entry;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Flush blocks both input handshakes so nothing is accepted in the clearing cycle.
    assign req_ready   = !flush && !full;
    assign rdata_ready = !flush && (!out_valid || out_ready);

    assign push   = req_valid && req_ready;
    assign pop    = rdata_valid && rdata_ready && !empty;
    // A consumed word with nothing outstanding has no owner; it is dropped and flagged.
    assign orphan = rdata_valid && rdata_ready && empty;

    assign head = mem[rd_ptr];

    always_comb begin
        wr_entry.op   = req_op;
        wr_entry.lo   = req_addr_lo;
        wr_entry.rt   = req_rt;
        wr_entry.wreg = req_wreg;
    end

    // Metadata storage; contents are only meaningful between push and pop so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Priority decode of the head op; an illegal multi-hot op resolves to the highest-priority bit,
    // and an all-zero op falls through to a plain word load.
    logic is_lwl;
    logic is_lwr;
    logic is_byte;
    logic is_half;
    logic sign_ext;

    always_comb begin
        is_lwl   = 1'b0;
        is_lwr   = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        sign_ext = 1'b0;
        if (head.op[6]) begin
            is_lwl = 1'b1;
        end else if (head.op[5]) begin
            is_lwr = 1'b1;
        end else if (head.op[4]) begin
            is_byte  = 1'b1;
            sign_ext = 1'b1;
        end else if (head.op[3]) begin
            is_byte = 1'b1;
        end else if (head.op[2]) begin
            is_half  = 1'b1;
            sign_ext = 1'b1;
        end else if (head.op[1]) begin
            is_half = 1'b1;
        end
    end

    // Lane selection for sub-word loads.
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (head.lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = head.lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unaligned-left merge: the addressed byte and everything below it in the word land in the top of rt.
    logic [31:0] lwl_val;

    always_comb begin
        lwl_val = rdata;
        case (head.lo)
            2'd0:    lwl_val = {rdata[7:0],  head.rt[23:0]};
            2'd1:    lwl_val = {rdata[15:0], head.rt[15:0]};
            2'd2:    lwl_val = {rdata[23:0], head.rt[7:0]};
            default: lwl_val = rdata;
        endcase
    end

    // Unaligned-right merge: the addressed byte and everything above it land in the bottom of rt.
    logic [31:0] lwr_val;

    always_comb begin
        lwr_val = rdata;
        case (head.lo)
            2'd0:    lwr_val = rdata;
            2'd1:    lwr_val = {head.rt[31:24], rdata[31:8]};
            2'd2:    lwr_val = {head.rt[31:16], rdata[31:16]};
            default: lwr_val = {head.rt[31:8],  rdata[31:24]};
        endcase
    end

    // Final writeback value; a misaligned halfword yields zero data plus the misalign flag.
    logic [31:0] res_wdata;
    logic        res_misalign;

    always_comb begin
        res_wdata    = rdata;
        res_misalign = 1'b0;
        if (is_lwl) begin
            res_wdata = lwl_val;
        end else if (is_lwr) begin
            res_wdata = lwr_val;
        end else if (is_byte) begin
            res_wdata = {{24{sign_ext & byte_lane[7]}}, byte_lane};
        end else if (is_half) begin
            if (head.lo[0]) begin
                res_wdata    = '0;
                res_misalign = 1'b1;
            end else begin
                res_wdata = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
        end
    end

    // Output register: load on pop, hold while WB stalls, clear once WB takes it with nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_wdata    <= '0;
            out_wreg     <= '0;
            out_misalign <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_wdata    <= '0;
            out_wreg     <= '0;
            out_misalign <= 1'b0;
        end else if (pop) begin
            out_valid    <= 1'b1;
            out_wdata    <= res_wdata;
            out_wreg     <= head.wreg;
            out_misalign <= res_misalign;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
            out_wdata    <= '0;
            out_wreg     <= '0;
            out_misalign <= 1'b0;
        end
    end

    // Sticky protocol-error flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (orphan) begin
            resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_return_aligner.sv
module tb_load_return_aligner;

    localparam int DEPTH = 2;
    localparam int REG_W = 5;

    localparam logic [6:0] OP_LWL = 7'b1000000;
    localparam logic [6:0] OP_LWR = 7'b0100000;
    localparam logic [6:0] OP_LB  = 7'b0010000;
    localparam logic [6:0] OP_LBU = 7'b0001000;
    localparam logic [6:0] OP_LH  = 7'b0000100;
    localparam logic [6:0] OP_LHU = 7'b0000010;
    localparam logic [6:0] OP_LW  = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_op;
    logic [1:0]       req_addr_lo;
    logic [31:0]      req_rt;
    logic [REG_W-1:0] req_wreg;
    logic             rdata_valid;
    logic             rdata_ready;
    logic [31:0]      rdata;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_wdata;
    logic [REG_W-1:0] out_wreg;
    logic             out_misalign;
    logic             resp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]       op;
        logic [1:0]       lo;
        logic [31:0]      rt;
        logic [REG_W-1:0] wreg;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    load_return_aligner #(.DEPTH(DEPTH), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr_lo(req_addr_lo), .req_rt(req_rt), .req_wreg(req_wreg),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata),
        .out_wreg(out_wreg), .out_misalign(out_misalign), .resp_err(resp_err)
    );

    // Reference result computed from the architectural rules with shifts and masks.
    function automatic void model_result(input logic [6:0] op, input logic [1:0] lo,
                                         input logic [31:0] rt, input logic [31:0] rd,
                                         output logic [31:0] wd, output logic mis);
        int sh;
        logic [31:0] v;
        sh  = 8 * int'(lo);
        mis = 1'b0;
        if (op[6]) begin
            wd = (rd << (24 - sh)) | (rt & ((32'h1 << (24 - sh)) - 32'h1));
        end else if (op[5]) begin
            wd = (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
        end else if (op[4] || op[3]) begin
            v = (rd >> sh) & 32'hFF;
            if (op[4] && v >= 32'd128) v = v - 32'd256;
            wd = v;
        end else if (op[2] || op[1]) begin
            if (lo[0]) begin
                wd  = 32'h0;
                mis = 1'b1;
            end else begin
                v = (rd >> sh) & 32'hFFFF;
                if (op[2] && v >= 32'd32768) v = v - 32'd65536;
                wd = v;
            end
        end else begin
            wd = rd;
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_op      = OP_LW;
        req_addr_lo = 2'd0;
        req_rt      = 32'h0;
        req_wreg    = '0;
        rdata_valid = 1'b0;
        rdata       = 32'h0;
        out_ready   = 1'b1;
    endtask

    // Issues one load and returns its word; on exit the result should sit in the output register.
    task automatic do_load(input logic [6:0] op, input logic [1:0] lo, input logic [31:0] rt,
                           input logic [REG_W-1:0] wreg, input logic [31:0] rd);
        req_valid   = 1'b1;
        req_op      = op;
        req_addr_lo = lo;
        req_rt      = rt;
        req_wreg    = wreg;
        tick();
        req_valid   = 1'b0;
        rdata_valid = 1'b1;
        rdata       = rd;
        tick();
        rdata_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_wdata !== 32'h0 || out_wreg !== '0 ||
            out_misalign !== 1'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h r=%h m=%b e=%b required all 0",
                     out_valid, out_wdata, out_wreg, out_misalign, resp_err);
        end
        checks++;
        if (req_ready !== 1'b1 || rdata_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got req_ready=%b rdata_ready=%b required 1/1", req_ready, rdata_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_extract;
        logic [6:0]  ops [10] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR, 7'b0000000,
                                  7'b1111111, 7'b0010100, OP_LH};
        logic [1:0]  los [10] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};
        logic [31:0] rts [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hAABB_CCDD, 32'hAABB_CCDD, 32'h0,
                                  32'hAABB_CCDD, 32'h0, 32'h0};
        logic [31:0] rds [10] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF,
                                  32'h1122_3344, 32'h1122_3344, 32'hDEAD_BEEF, 32'h1122_3344,
                                  32'h0000_00F0, 32'h8001_7FFF};
        logic [31:0] exp_d [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0,
                                    32'h3344_CCDD, 32'hAABB_1122, 32'hDEAD_BEEF, 32'h44BB_CCDD,
                                    32'hFFFF_FFF0, 32'h0};
        logic        exp_m [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            do_load(ops[i], los[i], rts[i], REG_W'(i + 1), rds[i]);
            checks++;
            if (out_valid !== 1'b1 || out_wdata !== exp_d[i] || out_misalign !== exp_m[i] ||
                out_wreg !== REG_W'(i + 1)) begin
                errors++;
                $display("FAIL extract_%0d: got v=%b d=%h m=%b r=%0d required v=1 d=%h m=%b r=%0d",
                         i, out_valid, out_wdata, out_misalign, out_wreg, exp_d[i], exp_m[i], i + 1);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL extract_clear_%0d: got out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        idle_inputs();
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_wreg  = 5'd10;
        tick();
        req_wreg  = 5'd11;
        tick();
        req_valid   = 1'b0;
        rdata_valid = 1'b1;
        rdata       = 32'hA5A5_0001;
        #1;
        checks++;
        if (rdata_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_ready: got rdata_ready=%b required 1", rdata_ready);
        end
        tick();
        rdata = 32'h5A5A_0002;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (rdata_ready !== 1'b0 || out_valid !== 1'b1 || out_wdata !== 32'hA5A5_0001 ||
                out_wreg !== 5'd10) begin
                errors++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b d=%h r=%0d required 0/1/a5a50001/10",
                         k, rdata_ready, out_valid, out_wdata, out_wreg);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (rdata_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got rdata_ready=%b required 1", rdata_ready);
        end
        tick();
        rdata_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_wdata !== 32'h5A5A_0002 || out_wreg !== 5'd11) begin
            errors++;
            $display("FAIL bp_second: got v=%b d=%h r=%0d required 1/5a5a0002/11", out_valid, out_wdata, out_wreg);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random_stream;
        logic             ev  = 1'b0;
        logic [31:0]      ewd = 32'h0;
        logic [REG_W-1:0] ewr = '0;
        logic             em  = 1'b0;
        logic             push;
        logic             pop;
        ent_t             e;
        int               sel;
        q.delete();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 8));
            if (sel < 7)       req_op = 7'(1 << sel);
            else if (sel == 7) req_op = 7'($urandom);
            else               req_op = 7'b0;
            req_addr_lo = 2'($urandom);
            req_rt      = $urandom;
            req_wreg    = REG_W'($urandom);
            rdata_valid = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            rdata       = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (req_ready !== (q.size() < DEPTH) || rdata_ready !== (!ev || out_ready)) begin
                errors++;
                $display("FAIL rnd_ready_%0d: got req_ready=%b rdata_ready=%b required %b/%b",
                         c, req_ready, rdata_ready, q.size() < DEPTH, !ev || out_ready);
            end
            checks++;
            if (out_valid !== ev || (ev && (out_wdata !== ewd || out_wreg !== ewr || out_misalign !== em))) begin
                errors++;
                $display("FAIL rnd_out_%0d: got v=%b d=%h r=%0d m=%b required v=%b d=%h r=%0d m=%b",
                         c, out_valid, out_wdata, out_wreg, out_misalign, ev, ewd, ewr, em);
            end
            checks++;
            if (resp_err !== 1'b0) begin
                errors++;
                $display("FAIL rnd_resp_err_%0d: got %b required 0", c, resp_err);
            end
            push = req_valid && (q.size() < DEPTH);
            pop  = rdata_valid && (!ev || out_ready) && (q.size() > 0);
            if (pop) begin
                e = q.pop_front();
                model_result(e.op, e.lo, e.rt, rdata, ewd, em);
                ewr = e.wreg;
                ev  = 1'b1;
            end else if (out_ready) begin
                ev = 1'b0;
            end
            if (push) q.push_back('{req_op, req_addr_lo, req_rt, req_wreg});
            tick();
        end
        idle_inputs();
        for (int k = 0; k < DEPTH + 2; k++) begin
            rdata_valid = (q.size() > 0);
            if (q.size() > 0) void'(q.pop_front());
            tick();
        end
        rdata_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush;
        idle_inputs();
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_wreg  = 5'd20;
        tick();
        req_wreg  = 5'd21;
        tick();
        req_valid   = 1'b0;
        rdata_valid = 1'b1;
        rdata       = 32'h0BAD_F00D;
        tick();
        rdata_valid = 1'b0;
        req_valid   = 1'b1;
        req_wreg    = 5'd22;
        tick();
        checks++;
        if (out_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre: got out_valid=%b req_ready=%b required 1/0", out_valid, req_ready);
        end
        flush       = 1'b1;
        req_wreg    = 5'd23;
        rdata_valid = 1'b1;
        out_ready   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got req_ready=%b rdata_ready=%b required 0/0", req_ready, rdata_ready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_post: got v=%b req_ready=%b err=%b required 0/1/0", out_valid, req_ready, resp_err);
        end
        do_load(OP_LW, 2'd0, 32'h0, 5'd25, 32'h1234_5678);
        checks++;
        if (out_valid !== 1'b1 || out_wreg !== 5'd25 || out_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL flush_after_load: got v=%b r=%0d d=%h required 1/25/12345678", out_valid, out_wreg, out_wdata);
        end
        tick();
    endtask

    task automatic test_full;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            req_valid = 1'b1;
            req_wreg  = REG_W'(i + 1);
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill_%0d: got req_ready=%b required 1", i, req_ready);
            end
            tick();
        end
        req_wreg    = 5'd31;
        rdata_valid = 1'b1;
        rdata       = 32'h100;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got req_ready=%b required 0", req_ready);
        end
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_wreg !== 5'd1 || out_wdata !== 32'h100 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_first_pop: got v=%b r=%0d d=%h req_ready=%b required 1/1/100/1",
                     out_valid, out_wreg, out_wdata, req_ready);
        end
        for (int i = 1; i < DEPTH; i++) begin
            rdata = 32'h100 + i;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_wreg !== REG_W'(i + 1) || out_wdata !== 32'h100 + i) begin
                errors++;
                $display("FAIL full_order_%0d: got v=%b r=%0d d=%h required 1/%0d/%h",
                         i, out_valid, out_wreg, out_wdata, i + 1, 32'h100 + i);
            end
        end
        rdata_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_resp_err;
        idle_inputs();
        rdata_valid = 1'b1;
        rdata       = 32'hFEED_FACE;
        tick();
        rdata_valid = 1'b0;
        checks++;
        if (resp_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_err_set: got err=%b v=%b required 1/0", resp_err, out_valid);
        end
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (resp_err !== 1'b1) begin
            errors++;
            $display("FAIL resp_err_sticky: got %b required 1", resp_err);
        end
    endtask

    task automatic test_async_reset;
        idle_inputs();
        out_ready = 1'b0;
        do_load(OP_LHU, 2'd1, 32'h0, 5'd7, 32'hFFFF_FFFF);
        req_valid = 1'b1;
        req_wreg  = 5'd8;
        tick();
        req_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_wreg !== 5'd7) begin
            errors++;
            $display("FAIL arst_pre: got v=%b m=%b r=%0d required 1/1/7", out_valid, out_misalign, out_wreg);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_wdata !== 32'h0 || out_wreg !== '0 || out_misalign !== 1'b0 ||
            resp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_outputs: got v=%b d=%h r=%0d m=%b e=%b req_ready=%b required 0/0/0/0/0/1",
                     out_valid, out_wdata, out_wreg, out_misalign, resp_err, req_ready);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        do_load(OP_LW, 2'd0, 32'h0, 5'd9, 32'hCAFE_0009);
        checks++;
        if (out_valid !== 1'b1 || out_wreg !== 5'd9 || out_wdata !== 32'hCAFE_0009) begin
            errors++;
            $display("FAIL arst_after_load: got v=%b r=%0d d=%h required 1/9/cafe0009", out_valid, out_wreg, out_wdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_extract();
        test_backpressure();
        test_random_stream();
        test_flush();
        test_full();
        test_resp_err();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
